load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: RD_LAT, default 1, number of cycles MemRead is held before MDR is sampled (legal 1-4).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  datapath request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access, 0 = 16-bit word access.
- req_signed  input  1  byte loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  16  byte address.
- req_wdata  input  16  store data; byte stores use bits [7:0].
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  16  load result.
- resp_err  output  1  request rejected (address 0xFFFF).
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- Address  output  16  data-memory byte address.
- Write_Data  output  16  data-memory write word.
- MDR  input  16  data-memory read word: {byte[Address+1], byte[Address]}, little-endian.

Function
REQ-003 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-004 SHALL assert req_ready only in IDLE while rst=0.
REQ-005 SHALL accept a request at the edge where req_valid=1 and req_ready=1, registering all req_* fields at that edge; req_* SHALL be ignored in every other state.
REQ-006 SHALL route an accepted request with req_addr=0xFFFF to RESP with resp_err=1 and resp_rdata=0x0000, and SHALL assert neither MemRead nor MemWrite for it.
REQ-007 SHALL handle the remaining requests as follows:
- Word load: RD, then RESP.
- Word store: WR, then RESP.
- Byte load: RD, then RESP.
- Byte store: RD, then WR, then RESP (read-modify-write).
REQ-008 SHALL hold MemRead=1 for exactly RD_LAT consecutive cycles in RD and SHALL capture MDR at the edge ending the last RD cycle.
REQ-009 SHALL hold MemWrite=1 for exactly one cycle in WR.
REQ-010 SHALL never assert MemRead and MemWrite in the same cycle, and SHALL hold both at 0 in IDLE and RESP.
REQ-011 SHALL drive Address and Write_Data from registers that change only at the accept edge and at the RD-to-WR edge, so that both are stable throughout and one cycle beyond any MemWrite assertion.
REQ-012 SHALL drive Write_Data as follows:
- Word store: req_wdata.
- Byte store: {captured MDR[15:8], req_wdata[7:0]}, written at Address.
REQ-013 SHALL form the load result as follows:
- Word load: captured MDR.
- Byte load, signed: {8{MDR[7]}, MDR[7:0]}.
- Byte load, unsigned: {8'h00, MDR[7:0]}.
- Stores: resp_rdata=0x0000.
REQ-014 SHALL assert resp_valid for exactly one cycle in RESP with no backpressure, hold resp_rdata and resp_err until the next RESP, then return to IDLE, with req_ready=1 in the following cycle.
REQ-015 SHALL meet these latencies, counting cycles after the accept edge (RESP cycle number):
- Error: 1.
- Word store: 2.
- Load: RD_LAT+1.
- Byte store: RD_LAT+2.

Reset
REQ-016 SHALL, while rst=1 at an edge, force state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0x0000, resp_err=0, MemRead=0, MemWrite=0, Address=0x0000 and Write_Data=0x0000.
REQ-017 SHALL abort any in-flight request on reset with no resp_valid for it; a memory write already strobed before the reset edge is not undone.

Verification
REQ-018 SHALL pass a word store/load check (RD_LAT=1): word store 0x1234 @0x0010 -> MemWrite pulse in cycle 1 and resp in cycle 2; word load @0x0010 -> resp_rdata=0x1234 in cycle 2.
REQ-019 SHALL pass a byte-store merge check: after REQ-018, byte store 0x00AB @0x0010 -> MemRead in cycle 1, MemWrite in cycle 2 with Write_Data=0x12AB, resp in cycle 3; word load @0x0010 -> 0x12AB.
REQ-020 SHALL pass a sign-extension check: byte store 0x0080 @0x0020 -> signed byte load @0x0020 = 0xFF80; unsigned byte load @0x0020 = 0x0080.
REQ-021 SHALL pass an error check: any request @0xFFFF -> resp_err=1 and resp_rdata=0x0000 in cycle 1, with MemRead and MemWrite never asserted.
REQ-022 SHALL pass a mid-operation reset check (RD_LAT=3): load @0x0010, rst=1 in cycle 2 -> MemRead=0 from the next cycle, no resp_valid, and req_ready=1 in the first cycle after rst returns to 0.
REQ-023 SHALL pass a busy-state check (RD_LAT=3): req_valid held at 1 continuously -> MemRead high in cycles 1-3, resp in cycle 4, next accept only at the edge after the IDLE cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges a single-request datapath port to a byte-addressed, 16-bit wide
//   data memory. It performs word loads and stores, byte loads with sign or
//   zero extension, and byte stores done as read-modify-write.
//
//   Handshake: a request is accepted on the rising edge where
//   req_valid && req_ready. req_ready is high only in IDLE with rst low.
//   Completion is a one-cycle resp_valid pulse with no backpressure.
//   resp_rdata and resp_err stay valid until the next completion.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_byte          1 = byte access, 0 = 16-bit word access
//   req_signed        byte loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address (0xFFFF is rejected with resp_err)
//   req_wdata         store data; byte stores use [7:0]
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and errors)
//   resp_err          request rejected
//   MemRead/MemWrite  data-memory strobes (never both high)
//   Address           data-memory byte address
//   Write_Data        data-memory write word
//   MDR               data-memory read word {byte[A+1], byte[A]}
//
// Parameter
//   RD_LAT            cycles MemRead is held before MDR is sampled (1..4)

module load_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [15:0] Address,
    output logic [15:0] Write_Data,
    input  logic [15:0] MDR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Value of rd_cnt in the last RD cycle.
    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    logic [1:0] state;
    logic [1:0] rd_cnt;
    logic       op_write;
    logic       op_byte;
    logic       op_signed;
    logic [7:0] op_wbyte;

    // Strobes and handshake decode straight from the state register, so
    // they are glitch-free and can never overlap.
    assign req_ready  = (state == S_IDLE) && !rst;
    assign MemRead    = (state == S_RD);
    assign MemWrite   = (state == S_WR);
    assign resp_valid = (state == S_RESP);

    function automatic logic [15:0] load_result(input logic [15:0] d,
                                                input logic        byt,
                                                input logic        sgn);
        logic [15:0] r;
        if (!byt)
            r = d;
        else if (sgn)
            r = {{8{d[7]}}, d[7:0]};
        else
            r = {8'h00, d[7:0]};
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_cnt     <= 2'd0;
            op_write   <= 1'b0;
            op_byte    <= 1'b0;
            op_signed  <= 1'b0;
            op_wbyte   <= 8'h00;
            Address    <= 16'h0000;
            Write_Data <= 16'h0000;
            resp_rdata <= 16'h0000;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        Address    <= req_addr;
                        Write_Data <= req_wdata;
                        op_write   <= req_write;
                        op_byte    <= req_byte;
                        op_signed  <= req_signed;
                        op_wbyte   <= req_wdata[7:0];
                        rd_cnt     <= 2'd0;
                        if (req_addr == 16'hFFFF) begin
                            // Rejected: complete next cycle, memory untouched.
                            resp_err   <= 1'b1;
                            resp_rdata <= 16'h0000;
                            state      <= S_RESP;
                        end else if (req_write && !req_byte) begin
                            state <= S_WR;
                        end else begin
                            // Loads and byte stores both start with a read.
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (rd_cnt == RD_LAST) begin
                        if (op_write) begin
                            // Byte store: keep the neighbouring byte from memory.
                            Write_Data <= {MDR[15:8], op_wbyte};
                            state      <= S_WR;
                        end else begin
                            resp_rdata <= load_result(MDR, op_byte, op_signed);
                            resp_err   <= 1'b0;
                            state      <= S_RESP;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                S_WR: begin
                    resp_rdata <= 16'h0000;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with RD_LAT=1 and one
// with RD_LAT=3, each backed by a small byte memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        valid;
    logic        r_write, r_byte, r_signed;
    logic [15:0] r_addr, r_wdata;

    logic        ready_a, rv_a, err_a, rd_a, wr_a;
    logic [15:0] rdata_a, addr_a, wd_a, mdr_a;
    logic        ready_b, rv_b, err_b, rd_b, wr_b;
    logic [15:0] rdata_b, addr_b, wd_b, mdr_b;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_store_unit #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid && !sel), .req_ready(ready_a),
        .req_write(r_write), .req_byte(r_byte), .req_signed(r_signed),
        .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rv_a),
        .resp_rdata(rdata_a), .resp_err(err_a), .MemRead(rd_a), .MemWrite(wr_a),
        .Address(addr_a), .Write_Data(wd_a), .MDR(mdr_a)
    );

    load_store_unit #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid && sel), .req_ready(ready_b),
        .req_write(r_write), .req_byte(r_byte), .req_signed(r_signed),
        .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rv_b),
        .resp_rdata(rdata_b), .resp_err(err_b), .MemRead(rd_b), .MemWrite(wr_b),
        .Address(addr_b), .Write_Data(wd_b), .MDR(mdr_b)
    );

    // Byte memories (low 8 address bits), little-endian word reads.
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] ia0, ia1, ib0, ib1;
    assign ia0   = addr_a[7:0];
    assign ia1   = addr_a[7:0] + 8'd1;
    assign ib0   = addr_b[7:0];
    assign ib1   = addr_b[7:0] + 8'd1;
    assign mdr_a = {mem_a[ia1], mem_a[ia0]};
    assign mdr_b = {mem_b[ib1], mem_b[ib0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
        end else begin
            if (wr_a) begin
                mem_a[ia0] <= wd_a[7:0];
                mem_a[ia1] <= wd_a[15:8];
            end
            if (wr_b) begin
                mem_b[ib0] <= wd_b[7:0];
                mem_b[ib1] <= wd_b[15:8];
            end
        end
    end

    // Observed signals of the selected instance.
    logic        o_ready, o_rv, o_err, o_rd, o_wr;
    logic [15:0] o_rdata, o_addr, o_wd;
    assign o_ready = sel ? ready_b : ready_a;
    assign o_rv    = sel ? rv_b    : rv_a;
    assign o_err   = sel ? err_b   : err_a;
    assign o_rd    = sel ? rd_b    : rd_a;
    assign o_wr    = sel ? wr_b    : wr_a;
    assign o_rdata = sel ? rdata_b : rdata_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_wd    = sel ? wd_b    : wd_a;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; cycle 1 is the first cycle after the accept edge.
    task automatic txn(input string tag, input logic s, input logic w, input logic b,
                       input logic sg, input logic [15:0] a, input logic [15:0] d,
                       input int exp_lat, input logic [15:0] exp_rdata, input logic exp_err,
                       input int exp_rd_first, input int exp_rd_n, input int exp_wr_cyc,
                       input logic [15:0] exp_wd);
        int cyc, lat, rd_first, rd_n, wr_cyc, both;
        logic [15:0] wd_seen, rdata_seen, wd_at_resp, addr_at_wr;
        logic err_seen;
        @(negedge clk);
        sel = s; r_write = w; r_byte = b; r_signed = sg; r_addr = a; r_wdata = d;
        check({tag, ":ready"}, 16'(o_ready), 16'h1);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        // Scramble the request bus: the unit must use its registered copy.
        r_write = 1'($urandom_range(0, 1)); r_byte = 1'($urandom_range(0, 1));
        r_signed = 1'($urandom_range(0, 1));
        r_addr = 16'($urandom_range(0, 65535)); r_wdata = 16'($urandom_range(0, 65535));
        lat = 0; rd_first = 0; rd_n = 0; wr_cyc = 0; both = 0;
        wd_seen = 16'h0; rdata_seen = 16'h0; err_seen = 1'b0;
        wd_at_resp = 16'h0; addr_at_wr = 16'h0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (o_rd && o_wr) both++;
            if (o_rd) begin
                rd_n++;
                if (rd_first == 0) rd_first = cyc;
            end
            if (o_wr) begin
                wr_cyc = cyc; wd_seen = o_wd; addr_at_wr = o_addr;
            end
            if (o_rv) begin
                lat = cyc; rdata_seen = o_rdata; err_seen = o_err; wd_at_resp = o_wd;
                break;
            end
            @(negedge clk);
        end
        check({tag, ":latency"}, 16'(lat), 16'(exp_lat));
        check({tag, ":rdata"}, rdata_seen, exp_rdata);
        check({tag, ":err"}, 16'(err_seen), 16'(exp_err));
        check({tag, ":rd_first"}, 16'(rd_first), 16'(exp_rd_first));
        check({tag, ":rd_cycles"}, 16'(rd_n), 16'(exp_rd_n));
        check({tag, ":wr_cycle"}, 16'(wr_cyc), 16'(exp_wr_cyc));
        check({tag, ":rd_wr_overlap"}, 16'(both), 16'h0);
        if (exp_wr_cyc != 0) begin
            check({tag, ":wdata"}, wd_seen, exp_wd);
            check({tag, ":waddr"}, addr_at_wr, a);
            check({tag, ":wdata_hold"}, wd_at_resp, exp_wd);
        end
        @(negedge clk);
        check({tag, ":ready_after"}, 16'(o_ready), 16'h1);
        check({tag, ":rv_single"}, 16'(o_rv), 16'h0);
        check({tag, ":rdata_held"}, o_rdata, exp_rdata);
    endtask

    initial begin : stim
        int seen;
        rst = 1'b1; sel = 1'b0; valid = 1'b0;
        r_write = 1'b0; r_byte = 1'b0; r_signed = 1'b0; r_addr = 16'h0; r_wdata = 16'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = (k == 1);
            #1;
            check("rst:ready", 16'(o_ready), 16'h0);
            check("rst:rv", 16'(o_rv), 16'h0);
            check("rst:rdata", o_rdata, 16'h0);
            check("rst:err", 16'(o_err), 16'h0);
            check("rst:memrd", 16'(o_rd), 16'h0);
            check("rst:memwr", 16'(o_wr), 16'h0);
            check("rst:addr", o_addr, 16'h0);
            check("rst:wd", o_wd, 16'h0);
        end
        rst = 1'b0;

        // RD_LAT = 1 instance.
        //   tag         s     w     b     sg    addr      wdata     lat rdata     err  rdf rdn wr wd
        txn("wst",      1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 2, 16'h0000, 1'b0, 0, 0, 1, 16'h1234);
        txn("wld",      1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 16'h1234, 1'b0, 1, 1, 0, 16'h0);
        txn("bst",      1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h00AB, 3, 16'h0000, 1'b0, 1, 1, 2, 16'h12AB);
        txn("wld2",     1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 16'h12AB, 1'b0, 1, 1, 0, 16'h0);
        txn("bst80",    1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0080, 3, 16'h0000, 1'b0, 1, 1, 2, 16'h0080);
        txn("bld_s",    1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 2, 16'hFF80, 1'b0, 1, 1, 0, 16'h0);
        txn("bld_u",    1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2, 16'h0080, 1'b0, 1, 1, 0, 16'h0);
        txn("err_ld",   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1'b1, 0, 0, 0, 16'h0);
        txn("err_st",   1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h5A5A, 1, 16'h0000, 1'b1, 0, 0, 0, 16'h0);
        txn("bld_odd",  1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 2, 16'h0012, 1'b0, 1, 1, 0, 16'h0);
        txn("bst_odd",  1'b0, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h55CD, 3, 16'h0000, 1'b0, 1, 1, 2, 16'h00CD);
        txn("wld3",     1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 16'hCDAB, 1'b0, 1, 1, 0, 16'h0);
        txn("bld_odd_s",1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 2, 16'hFFCD, 1'b0, 1, 1, 0, 16'h0);

        // RD_LAT = 3 instance.
        txn("b_wst",    1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF, 2, 16'h0000, 1'b0, 0, 0, 1, 16'hBEEF);
        txn("b_wld",    1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 4, 16'hBEEF, 1'b0, 1, 3, 0, 16'h0);
        txn("b_bst",    1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0011, 5, 16'h0000, 1'b0, 1, 3, 4, 16'hBE11);
        txn("b_err",    1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1'b1, 0, 0, 0, 16'h0);

        // Busy check: req_valid held high across two back-to-back loads.
        @(negedge clk);
        sel = 1'b1; r_write = 1'b0; r_byte = 1'b0; r_signed = 1'b0;
        r_addr = 16'h0040; r_wdata = 16'h0000;
        valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 3) check($sformatf("busy:memrd_c%0d", c), 16'(o_rd), 16'h1);
            if (c <= 4) check($sformatf("busy:ready_c%0d", c), 16'(o_ready), 16'h0);
            if (c == 4) begin
                check("busy:rv_c4", 16'(o_rv), 16'h1);
                check("busy:rdata_c4", o_rdata, 16'hBE11);
            end
            if (c == 5) begin
                check("busy:ready_c5", 16'(o_ready), 16'h1);
                check("busy:memrd_c5", 16'(o_rd), 16'h0);
            end
            if (c == 6) check("busy:memrd_c6", 16'(o_rd), 16'h1);
        end
        valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (o_rv) seen = 1;
            else @(negedge clk);
        end
        check("busy:second_resp", 16'(seen), 16'h1);
        @(negedge clk);

        // Mid-operation reset on the RD_LAT = 3 instance.
        @(negedge clk);
        sel = 1'b1; r_write = 1'b0; r_byte = 1'b0; r_addr = 16'h0010;
        valid = 1'b1;
        @(negedge clk);                       // cycle 1
        valid = 1'b0;
        check("mrst:memrd_c1", 16'(o_rd), 16'h1);
        @(negedge clk);                       // cycle 2
        rst = 1'b1;
        @(negedge clk);                       // cycle 3, after reset edge
        check("mrst:memrd_c3", 16'(o_rd), 16'h0);
        check("mrst:ready_in_rst", 16'(o_ready), 16'h0);
        check("mrst:addr", o_addr, 16'h0);
        check("mrst:rdata", o_rdata, 16'h0);
        seen = o_rv ? 1 : 0;
        rst = 1'b0;
        @(negedge clk);
        check("mrst:ready_after", 16'(o_ready), 16'h1);
        for (int c = 0; c < 6; c++) begin
            if (o_rv || o_rd) seen = 1;
            @(negedge clk);
        end
        check("mrst:no_resp", 16'(seen), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
